// File: rtl/mips_pkg.sv
// Shared processor-wide types and constants: operand width and the
// sequential multiplier's state encoding and iteration count.
package mips_pkg;

    localparam int DATA_32_W   = 32;
    localparam int MULT_CYCLES = 32;

    typedef enum logic [1:0] {
        MULT_IDLE,
        MULT_RUN,
        MULT_DONE
    } t_mult_state;

endpackage

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath: accumulator, left-shifting multiplicand and
// right-shifting multiplier; result is the post-step sum, optionally negated.
module mult_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 negate,
    input  logic [WIDTH-1:0]     mag_a,
    input  logic [WIDTH-1:0]     mag_b,
    output logic [2*WIDTH-1:0]   result
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] sum;

    // The sum already includes this cycle's partial product, so the FSM can
    // capture the final product on the same edge as the last step.
    assign sum    = acc + (mplier[0] ? mcand : '0);
    assign result = negate ? (~sum + (2*WIDTH)'(1)) : sum;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
        end else if (step) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mult_seq.sv
// Sequential signed multiplier: one shift-add step per cycle, sign applied at
// the end, pipeline stalled while a MULT is being accepted or running.
module mult_seq
    import mips_pkg::*;
#(
    parameter int WIDTH  = DATA_32_W,
    parameter int CYCLES = MULT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_X,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                CNT_W = $clog2(CYCLES) + 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CYCLES - 1);

    t_mult_state        state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               sign;
    logic               load, step, finish;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] result;

    // Magnitudes stay WIDTH bits unsigned: the most negative value maps onto
    // itself, which is exactly its magnitude when read as unsigned.
    assign mag_a = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
    assign mag_b = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;

    mult_shift_add #(.WIDTH(WIDTH)) u_shift_add (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .negate (sign),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .result (result)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            MULT_IDLE: begin
                if (start_X && !flush) begin
                    load       = 1'b1;
                    state_next = MULT_RUN;
                end
            end
            MULT_RUN: begin
                if (flush) begin
                    state_next = MULT_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == LAST) begin
                        finish     = 1'b1;
                        state_next = MULT_DONE;
                    end
                end
            end
            MULT_DONE: state_next = MULT_IDLE;
            default:   state_next = MULT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MULT_IDLE;
            cnt   <= '0;
            sign  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                cnt  <= '0;
                sign <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            end else if (step) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (finish) begin
                {hi, lo} <= result;
            end
        end
    end

    // Reset gates stall so a run aborted by reset never freezes the pipeline.
    assign stall = !rst && (((state == MULT_IDLE) && start_X && !flush) ||
                            (state == MULT_RUN));
    assign busy  = (state == MULT_RUN);
    assign done  = (state == MULT_DONE);

endmodule
